strassen_mm2x2_seq: RTL

//  Parametrised successor to the fixed 32-bit Strassen 2x2 block multiplier.

---
 rtl/strassen_mm2x2_seq.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/strassen_mm2x2_seq.sv
// Sequential 2x2 signed matrix multiplier: seven Strassen products through one multiplier.
// Define STRASSEN_SAT_EN to clamp each output element to OW bits instead of wrapping.
module strassen_mm2x2_seq #(
   parameter int DW      = 32,
   parameter int OW      = 32,
   parameter int MUL_REG = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4*DW-1:0] in_a,
   input  logic [4*DW-1:0] in_b,
   input  logic            in_sel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*OW-1:0] out_data,
   output logic            sat_flag
);

   localparam int AW = 2*DW + 4;
   localparam int PW = 2*DW + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DRAIN,
      S_FIN,
      S_OUT
   } state_t;

   state_t state_q, state_d;

   logic signed [DW-1:0] a11, a12, a21, a22;
   logic signed [DW-1:0] b11, b12, b21, b22;
   logic                 sel_q;
   logic [2:0]           idx_q;
   logic [2:0]           idx_last;

   logic signed [AW-1:0] acc11, acc12, acc21, acc22;
   logic signed [AW-1:0] d11, d12, d21, d22;

   logic signed [DW:0]   x, y;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] p_q;
   logic [2:0]           pidx_q;
   logic                 pvld_q;

   logic signed [PW-1:0] acc_p;
   logic signed [AW-1:0] pe;
   logic [2:0]           acc_idx;
   logic                 acc_en;

   logic [OW-1:0]        n11, n12, n21, n22;
   logic                 s11, s12, s21, s22;
   logic [4*OW-1:0]      out_next;
   logic                 sat_next;
   logic [4*OW-1:0]      out_q;
   logic                 sat_q;

   logic                 accept;

`ifdef STRASSEN_SAT_EN
   localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW-1:0] OMIN = ~OMAX;
`endif

   function automatic logic signed [DW:0] sx(input logic signed [DW-1:0] v);
      return {v[DW-1], v};
   endfunction

   function automatic logic [OW-1:0] narrow(
      input  logic signed [AW-1:0] v,
      output logic                 sat
   );
`ifdef STRASSEN_SAT_EN
      if (v > OMAX) begin
         sat = 1'b1;
         return OMAX[OW-1:0];
      end else if (v < OMIN) begin
         sat = 1'b1;
         return OMIN[OW-1:0];
      end else begin
         sat = 1'b0;
         return v[OW-1:0];
      end
`else
      sat = 1'b0;
      return v[OW-1:0];
`endif
   endfunction

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_OUT);
   assign out_data  = out_q;
   assign sat_flag  = sat_q;
   assign idx_last  = sel_q ? 3'd4 : 3'd6;

   // Pre-sum operand pair for product idx_q
   always_comb begin
      x = '0;
      y = '0;
      unique case (idx_q)
         3'd0: begin x = sx(a11) + sx(a22); y = sx(b11) + sx(b22); end
         3'd1: begin x = sx(a21) + sx(a22); y = sx(b11);           end
         3'd2: begin x = sx(a11);           y = sx(b12) - sx(b22); end
         3'd3: begin x = sx(a22);           y = sx(b21) - sx(b11); end
         3'd4: begin x = sx(a11) + sx(a12); y = sx(b22);           end
         3'd5: begin x = sx(a21) - sx(a11); y = sx(b11) + sx(b12); end
         3'd6: begin x = sx(a12) - sx(a22); y = sx(b21) + sx(b22); end
         default: ;
      endcase
   end

   assign prod = PW'(x) * PW'(y);

   always_comb begin
      if (MUL_REG != 0) begin
         acc_p   = p_q;
         acc_idx = pidx_q;
         acc_en  = pvld_q;
      end else begin
         acc_p   = prod;
         acc_idx = idx_q;
         acc_en  = (state_q == S_MUL);
      end
   end

   assign pe = AW'(acc_p);

   // Signed contribution of each product to the four result elements
   always_comb begin
      d11 = '0;
      d12 = '0;
      d21 = '0;
      d22 = '0;
      unique case (acc_idx)
         3'd0: begin d11 = pe;  d22 = pe;  end
         3'd1: begin d21 = pe;  d22 = -pe; end
         3'd2: begin d12 = pe;  d22 = pe;  end
         3'd3: begin d11 = pe;  d21 = pe;  end
         3'd4: begin d11 = -pe; d12 = pe;  end
         3'd5: begin d22 = pe;             end
         3'd6: begin d11 = pe;             end
         default: ;
      endcase
   end

   always_comb begin
      s11 = 1'b0;
      s12 = 1'b0;
      s21 = 1'b0;
      s22 = 1'b0;
      n11 = narrow(acc11, s11);
      n12 = narrow(acc12, s12);
      n21 = narrow(acc21, s21);
      n22 = narrow(acc22, s22);
      if (sel_q) begin
         n11 = '0;
         n22 = '0;
         s11 = 1'b0;
         s22 = 1'b0;
      end
      out_next = {n22, n21, n12, n11};
      sat_next = s11 | s12 | s21 | s22;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_MUL;
         S_MUL: begin
            if (idx_q == idx_last)
               state_d = (MUL_REG != 0) ? S_DRAIN : S_FIN;
         end
         S_DRAIN: state_d = S_FIN;
         S_FIN:   state_d = S_OUT;
         S_OUT:   if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a11    <= '0;
         a12    <= '0;
         a21    <= '0;
         a22    <= '0;
         b11    <= '0;
         b12    <= '0;
         b21    <= '0;
         b22    <= '0;
         sel_q  <= 1'b0;
         idx_q  <= '0;
         acc11  <= '0;
         acc12  <= '0;
         acc21  <= '0;
         acc22  <= '0;
         p_q    <= '0;
         pidx_q <= '0;
         pvld_q <= 1'b0;
         out_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         p_q    <= prod;
         pidx_q <= idx_q;
         pvld_q <= (MUL_REG != 0) && (state_q == S_MUL);
         if (acc_en) begin
            acc11 <= acc11 + d11;
            acc12 <= acc12 + d12;
            acc21 <= acc21 + d21;
            acc22 <= acc22 + d22;
         end
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  a11   <= in_a[DW-1:0];
                  a12   <= in_a[2*DW-1:DW];
                  a21   <= in_a[3*DW-1:2*DW];
                  a22   <= in_a[4*DW-1:3*DW];
                  b11   <= in_b[DW-1:0];
                  b12   <= in_b[2*DW-1:DW];
                  b21   <= in_b[3*DW-1:2*DW];
                  b22   <= in_b[4*DW-1:3*DW];
                  sel_q <= in_sel;
                  idx_q <= in_sel ? 3'd1 : 3'd0;
                  acc11 <= '0;
                  acc12 <= '0;
                  acc21 <= '0;
                  acc22 <= '0;
               end
            end
            S_MUL: idx_q <= idx_q + 3'd1;
            S_FIN: begin
               out_q <= out_next;
               sat_q <= sat_next;
            end
            default: ;
         endcase
      end
   end

endmodule
